flag_register: RTL
==================

// Module: flag_register
// PURPOSE
//  Producer side of the branch-condition path: derives Z/C/S/O from the ALU result of each
//  flag-setting instruction and holds them in a 4-bit status register.
//  Feeds test_flags through flags (registered) and flags_fwd (next-cycle value, bypass).
//  Adds a small LIFO so the UC can save/restore flags around call/interrupt sequences.
// PARAMETERS
//  WIDTH        16  ALU datapath width in bits
//  STACK_DEPTH   4  flag save-stack entries (power of 2, >=2)
// PORTS
//  clk          in   1      system clock, all state on rising edge
//  reset_n      in   1      synchronous reset, active-low
//  alu_result   in   WIDTH  ALU result of the current instruction
//  alu_a        in   WIDTH  ALU operand A (overflow detection)
//  alu_b        in   WIDTH  ALU operand B (overflow detection)
//  alu_carry    in   1      ALU carry/borrow out
//  alu_sub      in   1      1 = subtract-class op, 0 = add-class op (overflow rule select)
//  flag_wr      in   1      UC: update flags this cycle
//  flag_mask    in   4      UC: per-flag update enable, index Z=0 C=1 S=2 O=3
//  flag_push    in   1      UC: save current flags
//  flag_pop     in   1      UC: restore flags from stack top
//  flags        out  4      registered status {O,S,C,Z}, to test_flags
//  flags_fwd    out  4      combinational value flags takes at next edge
//  stack_depth  out  $clog2(STACK_DEPTH)+1  current number of saved entries
//  stack_err    out  1      sticky: push-full, pop-empty or push+pop collision
// BEHAVIOUR
//  Reset (reset_n=0 at edge): flags=4'b0000, stack_depth=0, stack_err=0; stack contents don't-care.
//  Flag derivation (combinational, new[3:0]):
//   Z = (alu_result == 0); S = alu_result[WIDTH-1]; C = alu_carry;
//   O add: alu_a[MSB]==alu_b[MSB] && alu_result[MSB]!=alu_a[MSB]
//   O sub: alu_a[MSB]!=alu_b[MSB] && alu_result[MSB]!=alu_a[MSB]
//  Update: flag_wr=1 -> flags[i] <= flag_mask[i] ? new[i] : flags[i]; latency 1 cycle.
//  flag_wr=1 with mask=0 leaves flags unchanged (legal, no error).
//  Push (push=1, pop=0): stack[depth] <= flags (pre-update value), depth+1.
//   Same-cycle flag_wr also applies to flags normally.
//  Pop (pop=1, push=0): flags <= stack[depth-1], depth-1; pop has priority over flag_wr (wr ignored).
//  Push when depth==STACK_DEPTH: no write, depth held, stack_err<=1.
//  Pop when depth==0: flags follow flag_wr rule as if no pop, stack_err<=1.
//  push=1 and pop=1: both ignored, stack_err<=1; flag_wr still applies.
//  stack_err clears only on reset; reset mid-sequence discards all saved entries.
//  flags_fwd = value flags will hold after the next edge (same priority rules above),
//   so test_flags may resolve a branch in the cycle directly after a flag-setting op.
//  No multi-cycle state machine; control is single-cycle, state = flags + stack + depth + err.
// STRUCTURE
//  Package flags_pkg: localparams FLAG_Z=0, FLAG_C=1, FLAG_S=2, FLAG_O=3;
//   typedef logic [3:0] flags_t; shared with test_flags and UC.
//  Sub-module flag_stack (LIFO, params DEPTH, W=4; push/pop/full/empty/depth/top).
//  flag_register holds flag derivation, update-mask merge, priority and error logic.
// TESTING
//  1 Reset: reset_n=0 one edge -> flags=0000, stack_depth=0, stack_err=0, flags_fwd=0000.
//  2 WIDTH=16 add 7FFF+0001=8000, carry=0, mask=1111, wr=1 -> flags_fwd=1100 same cycle,
//    flags=1100 (O=1 S=1 C=0 Z=0) next cycle.
//  3 Sub 0005-0005=0000, carry=1, mask=0001 from flags=1100 -> flags=1101 (only Z updated).
//  4 flags=1101; push; wr result 0001 mask=1111 -> flags=0000, depth=1; pop -> flags=1101,
//    depth=0.
//  5 Push 5 times at depth 4 -> depth stays 4, stack_err=1 and stays 1 until reset;
//    pop at depth 0 -> flags unchanged, stack_err=1.
//  6 push+pop same cycle with wr mask=0001 result 0 -> depth unchanged, Z set, stack_err=1;
//    pop+wr with depth=1 -> flags = stack top, wr ignored.

Source files
------------

// File: rtl/flags_pkg.sv
// flags_pkg: status flag bit positions and flag vector type
package flags_pkg;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_O = 3;
  typedef logic [3:0] flags_t;
endpackage

// File: rtl/flag_stack.sv
// flag_stack: small LIFO for saving/restoring status flags
module flag_stack #(
  parameter int DEPTH = 4,
  parameter int W = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic [AW:0]  depth,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] top_idx;
  assign full = depth == (AW+1)'(DEPTH);
  assign empty = depth == '0;
  assign top_idx = depth[AW-1:0] - 1'b1;
  assign top = empty ? '0 : mem[top_idx];
  always_ff @(posedge clk)
    if (push && !full) mem[depth[AW-1:0]] <= din;
  always_ff @(posedge clk)
    if (!reset_n) depth <= '0;
    else if (push && !full) depth <= depth + 1'b1;
    else if (pop && !empty) depth <= depth - 1'b1;
endmodule

// File: rtl/flag_register.sv
// flag_register: derives Z/C/S/O from ALU results and holds them with a save/restore stack
module flag_register
  import flags_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STACK_DEPTH = 4,
  localparam int DW = $clog2(STACK_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic             alu_carry,
  input  logic             alu_sub,
  input  logic             flag_wr,
  input  logic [3:0]       flag_mask,
  input  logic             flag_push,
  input  logic             flag_pop,
  output flags_t           flags,
  output flags_t           flags_fwd,
  output logic [DW-1:0]    stack_depth,
  output logic             stack_err
);
  flags_t nf, wr_val, top;
  logic full, empty, do_push, do_pop, err_nxt;
  logic ra, rb, rr;
  assign ra = alu_a[WIDTH-1];
  assign rb = alu_b[WIDTH-1];
  assign rr = alu_result[WIDTH-1];
  always_comb begin
    nf = '0;
    nf[FLAG_Z] = alu_result == '0;
    nf[FLAG_C] = alu_carry;
    nf[FLAG_S] = rr;
    nf[FLAG_O] = (alu_sub ? ra != rb : ra == rb) && rr != ra;
  end
  // a colliding push+pop or an impossible push/pop leaves the stack alone
  assign do_push = flag_push && !flag_pop && !full;
  assign do_pop = flag_pop && !flag_push && !empty;
  assign wr_val = flag_wr ? (flag_mask & nf) | (~flag_mask & flags) : flags;
  assign flags_fwd = do_pop ? top : wr_val;
  assign err_nxt = stack_err || (flag_push && flag_pop) ||
                   (flag_push && !flag_pop && full) || (flag_pop && !flag_push && empty);
  flag_stack #(.DEPTH(STACK_DEPTH), .W(4)) u_stack (
    .clk(clk), .reset_n(reset_n), .push(do_push), .pop(do_pop), .din(flags),
    .top(top), .depth(stack_depth), .full(full), .empty(empty)
  );
  always_ff @(posedge clk)
    if (!reset_n) begin
      flags <= '0;
      stack_err <= 1'b0;
    end else begin
      flags <= flags_fwd;
      stack_err <= err_nxt;
    end
endmodule
